// File: rtl/serial_logic16.sv
// Bit-serial bitwise logic unit: one gate evaluated per clock, LSB first,
// with valid/ready handshakes on operand intake and result delivery.
module serial_logic16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [1:0]       op_reg;
  logic [CW-1:0]    count;
  logic             gate_bit;
  logic             accept;
  logic             last_shift;

  assign accept     = (state == IDLE) && in_valid;
  assign last_shift = (state == SHIFT) && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    gate_bit = 1'b0;
    unique case (op_reg)
      2'b00: gate_bit = a_reg[0] & b_reg[0];
      2'b01: gate_bit = a_reg[0] | b_reg[0];
      2'b10: gate_bit = a_reg[0] ^ b_reg[0];
      2'b11: gate_bit = ~(a_reg[0] & b_reg[0]);
      default: gate_bit = 1'b0;
    endcase
  end

  // Result enters at the MSB so after WIDTH shifts bit i lines up with operand bit i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      res_reg <= '0;
      count   <= '0;
    end else if (accept) begin
      a_reg  <= in_a;
      b_reg  <= in_b;
      op_reg <= in_op;
      count  <= '0;
    end else if (state == SHIFT) begin
      a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
      b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
      res_reg <= {gate_bit, res_reg[WIDTH-1:1]};
      count   <= count + CW'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = res_reg;

endmodule

// File: tb/tb_serial_logic16.sv
// Directed bench for serial_logic16: latency, each op, backpressure,
// input isolation during SHIFT and asynchronous reset mid-operation.
module tb_serial_logic16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  serial_logic16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation at the current negedge and follows it to completion.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [1:0] op, input logic [15:0] exp, input bit scramble);
    check({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      if (scramble) begin
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_op    = 2'($urandom);
        in_valid = 1'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, "_valid_e15"}, {15'd0, out_valid}, 16'd0);
    check({tag, "_busy_e15"}, {15'd0, busy}, 16'd1);
    @(negedge clk);
    check({tag, "_valid_e16"}, {15'd0, out_valid}, 16'd1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_in_ready_done"}, {15'd0, in_ready}, 16'd0);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_valid_drop"}, {15'd0, out_valid}, 16'd0);
      check({tag, "_ready_back"}, {15'd0, in_ready}, 16'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Single AND, then back-to-back issue at 18-cycle spacing
    run("and", 16'hF0F0, 16'hFF00, 2'b00, 16'hF000, 1'b0);
    run("xor", 16'hAAAA, 16'h5555, 2'b10, 16'hFFFF, 1'b0);
    run("or", 16'h0001, 16'h8000, 2'b01, 16'h8001, 1'b0);
    run("nand", 16'hFFFF, 16'hFFFF, 2'b11, 16'h0000, 1'b0);
    run("nand2", 16'hF0F0, 16'hFF00, 2'b11, 16'h0FFF, 1'b0);

    // Backpressure: result held five cycles, in_valid pulse ignored
    out_ready = 1'b0;
    run("bp", 16'h1357, 16'h00FF, 2'b10, 16'h13A8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_a     = 16'hDEAD;
      in_b     = 16'hBEEF;
      in_op    = 2'b01;
      @(negedge clk);
      check("bp_valid", {15'd0, out_valid}, 16'd1);
      check("bp_data", out_data, 16'h13A8);
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    check("bp_no_accept", {15'd0, busy}, 16'd0);

    // Inputs scrambled every cycle while shifting
    run("scr_or", 16'h3C5A, 16'h0FF0, 2'b01, 16'h3FFA, 1'b1);
    run("scr_xor", 16'h3C5A, 16'h0FF0, 2'b10, 16'h33AA, 1'b1);

    // Asynchronous reset with count at 7
    in_valid = 1'b1;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    in_op    = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {15'd0, in_ready}, 16'd1);
    check("arst_out_valid", {15'd0, out_valid}, 16'd0);
    check("arst_busy", {15'd0, busy}, 16'd0);
    check("arst_out_data", out_data, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {15'd0, busy}, 16'd0);
    run("post_and", 16'h1234, 16'h0FF0, 2'b00, 16'h0230, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
